// File: rtl/stickman_motion_pkg.sv
// Shared constants and state encoding for the stickman vertical-motion block.
package stickman_motion_pkg;

  localparam logic [3:0] ST_WAIT = 4'b1000;
  localparam logic [3:0] ST_PLAY = 4'b0100;
  localparam logic [3:0] ST_WIN  = 4'b0010;
  localparam logic [3:0] ST_LOSE = 4'b0001;

  localparam logic [7:0] KEY_JUMP  = 8'h52;
  localparam logic [7:0] KEY_SPACE = 8'h2c;

  localparam logic [9:0] START_Y = 10'd300;
  localparam logic [9:0] STEP_UP = 10'd8;
  localparam logic [9:0] Y_MIN   = 10'd40;
  localparam logic [9:0] Y_MAX   = 10'd479;

  localparam logic signed [6:0] JUMP_V  = -7'sd12;
  localparam logic signed [6:0] GRAVITY = 7'sd1;
  localparam logic signed [6:0] VMAX    = 7'sd15;

  localparam logic [1:0] MAX_JUMPS = 2'd2;

  typedef enum logic [2:0] {HOLD, GROUND, RISE, FALL, FREEZE} motion_state_e;

  function automatic logic signed [10:0] sext_vel(input logic signed [6:0] v);
    return {{4{v[6]}}, v};
  endfunction

endpackage

// File: rtl/stickman_motion_tick.sv
// frame_tick_gen: brings the asynchronous frame clock into Clk and emits a
// one-cycle pulse on each rising edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);
  logic sync1, sync2, dly;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign frame_tick = sync2 & ~dly;
endmodule

// File: rtl/stickman_motion.sv
// Stickman vertical motion: ground following, double jump, gravity and landing,
// advanced once per frame tick and gated by the game status.
module stickman_motion
  import stickman_motion_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [3:0] status,
  input  logic [9:0] GroundY,
  output logic [9:0] StickmanBottom,
  output logic [6:0] VelY,
  output logic       Airborne,
  output logic [1:0] JumpsLeft
);
  motion_state_e     state, state_n;
  logic [9:0]        bottom, bottom_n;
  logic signed [6:0] vel, vel_n, v_eff;
  logic [1:0]        jumps, jumps_n;
  logic              air, air_n;
  logic              frame_tick, jump_req, can_jump, landing, do_step;
  logic [7:0]        key_prev;
  logic signed [10:0] sum, grd;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );

  // Only a fresh transition onto the jump key arms a request; a held key does not.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_prev <= 8'h00;
      jump_req <= 1'b0;
    end else begin
      key_prev <= keycode;
      if (keycode == KEY_JUMP && key_prev != KEY_JUMP) jump_req <= 1'b1;
      else if (frame_tick)                              jump_req <= 1'b0;
    end
  end

  // A ground jump takes its first airborne step with the launch velocity.
  assign v_eff    = (state == GROUND) ? JUMP_V : vel;
  assign sum      = $signed({1'b0, bottom}) + sext_vel(v_eff);
  assign grd      = $signed({1'b0, GroundY});
  assign can_jump = jump_req && (jumps != 2'd0);
  assign landing  = (state == FALL) && ($signed({1'b0, bottom}) <= grd) && (sum >= grd);

  always_comb begin
    state_n  = state;
    bottom_n = bottom;
    vel_n    = vel;
    jumps_n  = jumps;
    do_step  = 1'b0;
    if (status == ST_WAIT) begin
      state_n  = HOLD;
      bottom_n = START_Y;
      vel_n    = '0;
      jumps_n  = MAX_JUMPS;
    end else if (status == ST_WIN || status == ST_LOSE) begin
      state_n = FREEZE;
    end else begin
      case (state)
        HOLD: if (status == ST_PLAY) state_n = GROUND;
        GROUND: if (frame_tick) begin
          if (can_jump) do_step = 1'b1;
          else if (GroundY > bottom) begin
            vel_n   = '0;
            state_n = FALL;
          end else if (bottom - GroundY <= STEP_UP) bottom_n = GroundY;
        end
        RISE, FALL: if (frame_tick) begin
          if (landing) begin
            bottom_n = GroundY;
            vel_n    = '0;
            jumps_n  = MAX_JUMPS;
            state_n  = GROUND;
          end else do_step = 1'b1;
        end
        default: ;
      endcase
    end

    if (do_step) begin
      if (can_jump) jumps_n = jumps - 2'd1;
      if (state == GROUND)  vel_n = JUMP_V + GRAVITY;
      else if (can_jump)    vel_n = JUMP_V;
      else if (vel >= VMAX) vel_n = VMAX;
      else                  vel_n = vel + GRAVITY;
      if (sum < $signed({1'b0, Y_MIN})) begin
        bottom_n = Y_MIN;
        vel_n    = '0;
      end else if (sum > $signed({1'b0, Y_MAX})) bottom_n = Y_MAX;
      else bottom_n = sum[9:0];
      state_n = vel_n[6] ? RISE : FALL;
    end

    // Airborne is registered so it freezes along with everything else.
    air_n = (state_n == FREEZE) ? air : (state_n == RISE || state_n == FALL);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= HOLD;
      bottom <= START_Y;
      vel    <= '0;
      jumps  <= MAX_JUMPS;
      air    <= 1'b0;
    end else begin
      state  <= state_n;
      bottom <= bottom_n;
      vel    <= vel_n;
      jumps  <= jumps_n;
      air    <= air_n;
    end
  end

  assign StickmanBottom = bottom;
  assign VelY           = vel;
  assign JumpsLeft      = jumps;
  assign Airborne       = air;
endmodule

// File: tb/tb_stickman_motion.sv
// Vector-table bench for stickman_motion with a queue of expected snapshots.
module tb_stickman_motion;
  import stickman_motion_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, Airborne;
  logic [7:0] keycode;
  logic [3:0] status;
  logic [9:0] GroundY, StickmanBottom;
  logic [6:0] VelY;
  logic [1:0] JumpsLeft;

  stickman_motion dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .keycode       (keycode),
    .status        (status),
    .GroundY       (GroundY),
    .StickmanBottom(StickmanBottom),
    .VelY          (VelY),
    .Airborne      (Airborne),
    .JumpsLeft     (JumpsLeft)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic [3:0] st;
    int         gy;
    bit         press;
    int         ticks;
    int         bot;
    int         vel;
    int         jmp;
    bit         air;
  } vec_t;

  typedef struct {
    string nm;
    int    bot;
    int    vel;
    int    jmp;
    bit    air;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_push(input string nm, input int b, input int v, input int j, input bit a);
    exp_t e;
    e.nm = nm; e.bot = b; e.vel = v; e.jmp = j; e.air = a;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    int   av;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: nothing expected");
      return;
    end
    e  = sbq.pop_front();
    av = int'($signed(VelY));
    if (StickmanBottom !== 10'(e.bot) || $signed(VelY) !== e.vel ||
        JumpsLeft !== 2'(e.jmp) || Airborne !== e.air) begin
      bad++;
      $display("FAIL %s: got bot=%0d vel=%0d jmp=%0d air=%0b, want bot=%0d vel=%0d jmp=%0d air=%0b",
               e.nm, StickmanBottom, av, JumpsLeft, Airborne, e.bot, e.vel, e.jmp, e.air);
    end
  endtask

  task automatic tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic press();
    @(negedge Clk) keycode = KEY_JUMP;
    @(negedge Clk) keycode = KEY_SPACE;
  endtask

  task automatic add(input logic [3:0] st, input int gy, input bit p, input int n,
                     input int b, input int v, input int j, input bit a);
    vec_t r;
    r.st = st; r.gy = gy; r.press = p; r.ticks = n;
    r.bot = b; r.vel = v; r.jmp = j; r.air = a;
    vecs.push_back(r);
  endtask

  initial begin
    // single jump: 288 after tick 1, apex 222 at tick 12, lands tick 25
    add(ST_PLAY, 300, 1, 1,  288, -11, 1, 1);
    add(ST_PLAY, 300, 0, 11, 222,   0, 1, 1);
    add(ST_PLAY, 300, 0, 13, 300,   0, 2, 0);
    // double jump at apex, third press ignored, fall with saturation
    add(ST_PLAY, 300, 1, 1,  288, -11, 1, 1);
    add(ST_PLAY, 300, 0, 11, 222,   0, 1, 1);
    add(ST_PLAY, 300, 1, 1,  222, -12, 0, 1);
    add(ST_PLAY, 300, 1, 1,  210, -11, 0, 1);
    add(ST_PLAY, 300, 0, 11, 144,   0, 0, 1);
    add(ST_PLAY, 300, 0, 18, 294,  15, 0, 1);
    add(ST_PLAY, 300, 0, 1,  300,   0, 2, 0);
    // step too tall held, small step snapped
    add(ST_PLAY, 250, 0, 1,  300,   0, 2, 0);
    add(ST_PLAY, 295, 0, 1,  295,   0, 2, 0);
    // ground drops to 400
    add(ST_PLAY, 400, 0, 1,  295,   0, 2, 1);
    add(ST_PLAY, 400, 0, 3,  298,   3, 2, 1);
    add(ST_PLAY, 400, 0, 11, 386,  14, 2, 1);
    add(ST_PLAY, 400, 0, 1,  400,   0, 2, 0);
    // pit: clamp at 479, freeze, then wait restores start
    add(ST_PLAY, 500, 0, 15, 479,  14, 2, 1);
    add(ST_PLAY, 500, 0, 2,  479,  15, 2, 1);
    add(ST_LOSE, 500, 0, 3,  479,  15, 2, 1);
    add(ST_WAIT, 500, 0, 0,  300,   0, 2, 0);
    add(ST_PLAY, 300, 0, 0,  300,   0, 2, 0);

    Reset = 1'b1; frame_clk = 1'b0; keycode = KEY_SPACE; status = ST_WAIT; GroundY = 10'd300;
    expect_push("reset", 300, 0, 2, 0);
    repeat (3) @(negedge Clk);
    pop_check();
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < vecs.size(); i++) begin
      status  = vecs[i].st;
      GroundY = 10'(vecs[i].gy);
      expect_push($sformatf("row%0d", i), vecs[i].bot, vecs[i].vel, vecs[i].jmp, vecs[i].air);
      if (vecs[i].press) press();
      if (vecs[i].ticks == 0) @(negedge Clk);
      for (int t = 0; t < vecs[i].ticks; t++) tick();
      pop_check();
    end

    // held jump key across 10 frames gives one jump only
    @(negedge Clk) keycode = KEY_JUMP;
    expect_push("held_key", 225, -2, 1, 1);
    for (int t = 0; t < 10; t++) tick();
    pop_check();

    // reset mid-rise acts on the very next edge
    @(negedge Clk) begin Reset = 1'b1; keycode = KEY_SPACE; end
    expect_push("reset_mid_rise", 300, 0, 2, 0);
    @(negedge Clk);
    pop_check();
    @(negedge Clk) Reset = 1'b0;
    @(negedge Clk);

    // three-cycle latency from frame_clk rise to output change
    press();
    @(negedge Clk) frame_clk = 1'b1;
    expect_push("lat_edge1", 300, 0, 2, 0);
    @(negedge Clk); pop_check();
    expect_push("lat_edge2", 300, 0, 2, 0);
    @(negedge Clk); pop_check();
    expect_push("lat_edge3", 288, -11, 1, 1);
    @(negedge Clk); pop_check();
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
